// File: rtl/cmip_fifo_wr_arbiter.sv
// cmip_fifo_wr_arbiter: packet-level round-robin arbiter for one async FIFO write port.
// Define CMIP_FIFO_ARB_HDR_EN to prepend a header word to every granted packet.
module cmip_fifo_wr_arbiter #(
  parameter int NCH       = 4,
  parameter int DATA_WDTH = 512,
  parameter int DPTH      = 32,
  parameter int MAX_PKT   = 8,
  parameter int CNT_LAT   = 2,
  parameter int ADDR_WDTH = $clog2(DPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NCH-1:0]           i_req_vld,
  input  logic [NCH-1:0]           i_req_last,
  input  logic [NCH*DATA_WDTH-1:0] i_req_data,
  output logic [NCH-1:0]           o_req_rdy,
  input  logic [ADDR_WDTH:0]       i_fifo_wr_cnt,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_wr,
  output logic [DATA_WDTH-1:0]     o_fifo_din,
  output logic [$clog2(NCH)-1:0]   o_grant_id,
  output logic                     o_busy,
  output logic                     o_trunc_int
);

  localparam int GW  = $clog2(NCH);
  localparam int CW  = $clog2(MAX_PKT + 1);
  localparam int LW  = (CNT_LAT > 1) ? $clog2(CNT_LAT) : 1;
  localparam int AW1 = ADDR_WDTH + 1;

`ifdef CMIP_FIFO_ARB_HDR_EN
  localparam logic [AW1-1:0] NEED = AW1'(MAX_PKT + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_HDR, S_XFER, S_GAP
  } state_t;
`else
  localparam logic [AW1-1:0] NEED = AW1'(MAX_PKT);
  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_XFER, S_GAP
  } state_t;
`endif

  localparam logic [CW-1:0] CNT_END = CW'(MAX_PKT - 1);
  localparam logic [LW-1:0] GAP_END = LW'(CNT_LAT - 1);

  state_t                 state_q, state_d;
  logic [GW-1:0]          rr_q, rr_d;
  logic [GW-1:0]          gnt_q, gnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          gap_q, gap_d;
  logic                   wr_q, wr_d;
  logic [DATA_WDTH-1:0]   din_q, din_d;
  logic                   trunc_q, trunc_d;
  logic [NCH-1:0]         rdy;
  logic [AW1-1:0]         free;
  logic [GW-1:0]          pick;
  logic [GW-1:0]          idx;
  logic                   pick_vld;
  logic [DATA_WDTH-1:0]   cur;

  assign free = AW1'(DPTH) - i_fifo_wr_cnt;
  assign cur  = i_req_data[int'(gnt_q)*DATA_WDTH +: DATA_WDTH];

`ifdef CMIP_FIFO_ARB_HDR_EN
  logic [DATA_WDTH-1:0] hdr;
  // Header word: grant id and packet limit in the low 24 bits.
  always_comb begin
    hdr = '0;
    hdr[23:0] = {8'(gnt_q), 16'(MAX_PKT)};
  end
`endif

  // Round-robin search upward from the pointer, wrapping around.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = GW'((int'(rr_q) + i) % NCH);
      if (!pick_vld && i_req_vld[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, grant bookkeeping and write-port drive.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    wr_d    = 1'b0;
    din_d   = din_q;
    trunc_d = 1'b0;
    rdy     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|i_req_vld && free >= NEED)
          state_d = S_ARB;
      end
      S_ARB: begin
        cnt_d = '0;
        if (pick_vld) begin
          gnt_d = pick;
          rr_d  = pick;
`ifdef CMIP_FIFO_ARB_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef CMIP_FIFO_ARB_HDR_EN
      S_HDR: begin
        if (!i_fifo_full) begin
          wr_d    = 1'b1;
          din_d   = hdr;
          state_d = S_XFER;
        end
      end
`endif
      S_XFER: begin
        rdy[gnt_q] = ~i_fifo_full;
        if (i_req_vld[gnt_q] && !i_fifo_full) begin
          wr_d  = 1'b1;
          din_d = cur;
          cnt_d = cnt_q + 1'b1;
          if (i_req_last[gnt_q] || cnt_q == CNT_END) begin
            trunc_d = ~i_req_last[gnt_q];
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_END)
          state_d = S_IDLE;
        else
          gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset returns to IDLE at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rr_q    <= GW'(NCH - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      trunc_q <= trunc_d;
    end
  end

  assign o_req_rdy   = rdy;
  assign o_fifo_wr   = wr_q;
  assign o_fifo_din  = din_q;
  assign o_grant_id  = gnt_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_trunc_int = trunc_q;

endmodule
